// File: rtl/button_pulse_conditioner.sv
// Button input stage with a two-flop synchroniser and a debounce FSM.
// It drives a registered one-cycle `pulse` per accepted press, with optional
// auto-repeat while the button is held, and a registered debounced `level`.
// Valid/ready does not apply here: `pulse` is a fire-and-forget strobe, and any
// consumer must sample it on the single cycle it is high.
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic pulse_en,
    output logic pulse,
    output logic level
);

    // One counter width covers the debounce window and both repeat intervals.
    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    logic          first_q, first_d;
    logic          pulse_q, pulse_d;
    logic          level_q, level_d;
    logic          event_d;

    // Next-state logic. It handles the debounce windows, repeat timing and the
    // registered outputs. Each state change clears the debounce counter.
    always_comb begin
        s1_d      = btn_in;
        s2_d      = s1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rep_cnt_d = rep_cnt_q;
        first_d   = first_q;
        event_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s2_q) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = S_HELD;
                    cnt_d     = '0;
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
                    event_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HELD: begin
                if (!s2_q) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rep_cnt_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
                        rep_cnt_d = '0;
                        first_d   = 1'b0;
                        event_d   = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_ONE;
                    end
                end
            end
            S_RELEASE_WAIT: begin
                if (s2_q) begin
                    // A bounce back to high resumes the hold without a new press.
                    state_d   = S_HELD;
                    cnt_d     = '0;
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (REPEAT_EN == 0) begin
            rep_cnt_d = '0;
        end

        // pulse_en gates only the strobe. The FSM and level ignore it.
        pulse_d = event_d & pulse_en;
        level_d = (state_d == S_HELD) || (state_d == S_RELEASE_WAIT);
    end

    // State, synchroniser and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rep_cnt_q <= '0;
            first_q   <= 1'b0;
            pulse_q   <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rep_cnt_q <= rep_cnt_d;
            first_q   <= first_d;
            pulse_q   <= pulse_d;
            level_q   <= level_d;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner. Two instances share one set of inputs.
// One has repeat disabled and one has it enabled. Both are compared every
// cycle against a run-length reference model. Directed tables and
// hand-written sequences cover the multi-cycle corner cases.
module tb_button_pulse_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic pulse_en;
    logic pulse_n, level_n;
    logic pulse_r, level_r;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_n (
        .clk(clk), .reset(reset), .btn_in(btn_in), .pulse_en(pulse_en),
        .pulse(pulse_n), .level(level_n)
    );

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_r (
        .clk(clk), .reset(reset), .btn_in(btn_in), .pulse_en(pulse_en),
        .pulse(pulse_r), .level(level_r)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The button value seen by the debouncer is btn_in delayed by two edges.
    // The level toggles once D+1 consecutive samples disagree with it. Repeats
    // fire RD, RD+RP, RD+2RP, ... samples into an uninterrupted hold.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_prev = 1'b0;
    logic m_lvl[2];
    int   m_run[2];
    int   m_hold[2];
    logic m_ev;
    logic exp_pulse[2];
    logic exp_level[2];

    function automatic bit repeat_due(input int h);
        return (h == RD) || (h > RD && ((h - RD) % RP) == 0);
    endfunction

    // Reference model: advances one clock edge at each posedge.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0;
            for (int m = 0; m < 2; m++) begin
                m_lvl[m] = 1'b0; m_run[m] = 0; m_hold[m] = 0;
                exp_pulse[m] = 1'b0; exp_level[m] = 1'b0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                m_ev = 1'b0;
                if (m_s2 != m_lvl[m]) begin
                    m_run[m]++;
                    if (m_run[m] == D + 1) begin
                        m_lvl[m] = ~m_lvl[m];
                        m_run[m] = 0;
                        if (m_lvl[m]) begin
                            m_ev = 1'b1;
                            m_hold[m] = 0;
                        end
                    end
                end else begin
                    m_run[m] = 0;
                    if (m_lvl[m] && m_s2) begin
                        if (!m_prev) m_hold[m] = 0;
                        else begin
                            m_hold[m]++;
                            if (m == 1 && repeat_due(m_hold[m])) m_ev = 1'b1;
                        end
                    end
                end
                exp_pulse[m] = m_ev & pulse_en;
                exp_level[m] = m_lvl[m];
            end
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = btn_in;
        end
    end

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("mdl_pulse_norep", pulse_n, exp_pulse[0]);
            check("mdl_level_norep", level_n, exp_level[0]);
            check("mdl_pulse_rep",   pulse_r, exp_pulse[1]);
            check("mdl_level_rep",   level_r, exp_level[1]);
        end
    end

    // ---------------- directed table ----------------
    typedef struct packed {
        logic rst;
        logic btn;
        logic pen;
        logic exp_pulse;
        logic exp_level;
    } vec_t;

    vec_t vec[$];

    task automatic add_rows(input int n, input logic rst, input logic btn, input logic pen,
                            input logic ep, input logic el);
        vec_t v;
        v = '{rst: rst, btn: btn, pen: pen, exp_pulse: ep, exp_level: el};
        for (int i = 0; i < n; i++) vec.push_back(v);
    endtask

    task automatic run_table();
        for (int i = 0; i < vec.size(); i++) begin
            reset    = vec[i].rst;
            btn_in   = vec[i].btn;
            pulse_en = vec[i].pen;
            @(negedge clk);
            check("tbl_pulse", pulse_n, vec[i].exp_pulse);
            check("tbl_level", level_n, vec[i].exp_level);
        end
    endtask

    // ---------------- hand-written sequences ----------------
    task automatic seq_release_bounce();
        int pc;
        int low_edge;
        pc = 0;
        low_edge = 0;
        pulse_en = 1'b1;
        btn_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pulse_n) pc++;
        end
        for (int t = 0; t < 10; t++) begin
            btn_in = ((t / 2) % 2 == 1);
            @(negedge clk);
            if (pulse_n) pc++;
            if (t == 8) low_edge = cyc;
        end
        btn_in = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (pulse_n) pc++;
            if (cyc == low_edge + D + 1) check("bounce_level_hold", level_n, 1'b1);
            if (cyc == low_edge + D + 2) check("bounce_level_fall", level_n, 1'b0);
        end
        check_int("bounce_pulse_count", pc, 1);
    endtask

    logic [15:0] exp_q[$];

    task automatic seq_repeat();
        int k;
        logic [15:0] e;
        k = 0;
        pulse_en = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 54; i++) begin
            btn_in = (i < 34);
            @(negedge clk);
            if (i == 0) begin
                k = cyc;
                exp_q.push_back(16'(k + D + 2));
                exp_q.push_back(16'(k + D + 2 + RD));
                for (int j = 1; j <= 3; j++) exp_q.push_back(16'(k + D + 2 + RD + j * RP));
            end
            if (pulse_r) begin
                if (exp_q.size() == 0) begin
                    check_int("repeat_extra_pulse_edge", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    check_int("repeat_pulse_edge", cyc, int'(e));
                end
            end
        end
        check_int("repeat_missing_pulses", exp_q.size(), 0);
    endtask

    task automatic seq_reset();
        int w;
        int k;
        int pc;
        w = 0;
        k = 0;
        pc = 0;
        pulse_en = 1'b1;
        btn_in = 1'b1;
        while (level_n !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_reach_held", level_n, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pulse_low", pulse_n, 1'b0);
        check("rst_level_low", level_n, 1'b0);
        check("rst_level_low_rep", level_r, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) k = cyc;
            check("rst_repress_pulse", pulse_n, logic'(cyc == k + D + 2));
            if (pulse_n) pc++;
        end
        check_int("rst_repress_count", pc, 1);
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run_random();
        int len;
        logic b;
        for (int seg = 0; seg < 250; seg++) begin
            b = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                btn_in   = b;
                pulse_en = ($urandom_range(0, 9) != 0);
                reset    = ($urandom_range(0, 199) == 0);
                @(negedge clk);
            end
        end
        reset = 1'b0;
        btn_in = 1'b0;
        pulse_en = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        btn_in = 1'b0;
        pulse_en = 1'b1;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;

        // rows: rst, btn, pen, exp_pulse, exp_level
        add_rows(1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // reset edge
        add_rows(9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // idle, edges 1..9
        add_rows(6,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // press sampled at 10
        add_rows(1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1);  // accepted at edge 16
        add_rows(33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);  // held
        add_rows(6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1);  // release from 50
        add_rows(4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // level low from 56
        add_rows(3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // 3-cycle glitch
        add_rows(8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_rows(6,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // press, pulse_en=0
        add_rows(1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);  // accepted, strobe suppressed
        add_rows(8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add_rows(6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        add_rows(8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_rows(6,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // press, pulse_en=1
        add_rows(1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        add_rows(4,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        add_rows(6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        add_rows(4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        run_table();
        seq_release_bounce();
        seq_repeat();
        seq_reset();
        run_random();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
